// File: rtl/rand_pkg.sv
// Shared types and helpers for the random-number server: LFSR width,
// lockup value, FSM state encoding and the LFSR feedback function.
package rand_pkg;
  localparam int LFSR_W = 6;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 6'h3F;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  // XNOR feedback for x^6+x^5+1; all-ones is the single unreachable state
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[4:0], ~(s[5] ^ s[4])};
  endfunction
endpackage

// File: rtl/rand_server_lfsr6.sv
// 6-bit XNOR LFSR with synchronous seed load; a lockup seed is replaced
// by zero so the register can never stick.
module lfsr6
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] out
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     out <= '0;
    else if (load) out <= (seed == LFSR_LOCKUP) ? '0 : seed;
    else           out <= lfsr_next(out);
  end
endmodule

// File: rtl/rand_server.sv
// Round-robin server handing out LFSR draws in [0, limit] by bounded
// rejection sampling; one shared LFSR so no two consumers see the same draw.
module rand_server
  import rand_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [LFSR_W*N_REQ-1:0] limit,
  input  logic                    seed_load,
  input  logic [LFSR_W-1:0]       seed,
  output logic [N_REQ-1:0]        ack,
  output logic [LFSR_W-1:0]       rdata,
  output logic                    timeout,
  output logic                    busy
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [5:0] LAST_TRY = 6'(MAX_TRIES - 1);

  state_t            state;
  logic [IW-1:0]     idx, ptr, pick, j;
  logic              found, load;
  logic [LFSR_W-1:0] lim, s;
  logic [5:0]        tries;
  logic [N_REQ-1:0]  sel;
  logic [LFSR_W-1:0] lim_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lim
    assign lim_arr[g] = limit[LFSR_W*g +: LFSR_W];
  end

  // A seed load in IDLE wins over a grant; the grant waits one edge
  assign load = (state == S_IDLE) && seed_load;

  lfsr6 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .seed (seed),
    .out  (s)
  );

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      ptr     <= IW'(N_REQ - 1);
      lim     <= '0;
      tries   <= '0;
      ack     <= '0;
      rdata   <= '0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ack     <= '0;
          rdata   <= '0;
          timeout <= 1'b0;
          if (!seed_load && found) begin
            idx   <= pick;
            ptr   <= pick;
            lim   <= lim_arr[pick];
            tries <= '0;
            busy  <= 1'b1;
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (s <= lim) begin
            ack     <= sel;
            rdata   <= s;
            timeout <= 1'b0;
            state   <= S_DONE;
          end else if (tries == LAST_TRY) begin
            ack     <= sel;
            rdata   <= lim;
            timeout <= 1'b1;
            state   <= S_DONE;
          end else begin
            tries <= tries + 6'd1;
          end
        end
        S_DONE: begin
          ack     <= '0;
          rdata   <= '0;
          timeout <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rand_server.sv
// Self-checking bench for rand_server: transaction-level model of arbitration
// and rejection sampling driven by a free-running reference LFSR.
module tb_rand_server;
  import rand_pkg::*;
  localparam int N_REQ = 4;
  localparam int MAX_TRIES = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [6*N_REQ-1:0]   limit = '0;
  logic                 seed_load = 1'b0;
  logic [5:0]           seed = '0;
  logic [N_REQ-1:0]     ack;
  logic [5:0]           rdata;
  logic                 timeout;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic [5:0] m_lfsr;
  bit         m_load = 1'b0;
  int         m_ptr = N_REQ - 1;

  rand_server #(.N_REQ(N_REQ), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .reset(reset), .req(req), .limit(limit),
    .seed_load(seed_load), .seed(seed),
    .ack(ack), .rdata(rdata), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Next state of x^6+x^5+1 XNOR register, in plain arithmetic
  function automatic logic [5:0] step(input logic [5:0] x);
    int v;
    v = int'(x);
    return 6'(((v * 2) % 64) + ((((v / 32) % 2) == ((v / 16) % 2)) ? 1 : 0));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset)       m_lfsr <= 6'h00;
    else if (m_load) m_lfsr <= (seed == 6'h3F) ? 6'h00 : seed;
    else             m_lfsr <= step(m_lfsr);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    seed_load = 1'b0;
    m_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = N_REQ - 1;
  endtask

  // Called at a negedge in IDLE with req already driven; ends at the ack negedge
  task automatic serve(input bit perturb, output int who,
                       output logic [5:0] got_r, output logic got_to);
    logic [5:0] v, lim, d, er;
    logic [N_REQ-1:0] eack;
    bit hit, eto;
    int k;
    who = -1;
    got_r = '0;
    got_to = 1'b0;
    for (int i = 1; i <= N_REQ; i++)
      if (who < 0 && req[(m_ptr + i) % N_REQ]) who = (m_ptr + i) % N_REQ;
    checks++;
    if (who < 0) begin
      errors++;
      $display("FAIL serve_no_req: req=%b nothing to grant", req);
      return;
    end
    lim = limit[6*who +: 6];
    m_ptr = who;
    @(posedge clk);
    #1;
    v = m_lfsr;
    hit = 1'b0; k = MAX_TRIES - 1; er = lim; eto = 1'b1; d = v;
    for (int i = 0; i < MAX_TRIES; i++) begin
      if (!hit) begin
        if (d <= lim) begin
          hit = 1'b1; k = i; er = d; eto = 1'b0;
        end else d = step(d);
      end
    end
    for (int n = 1; n <= k + 1; n++) begin
      @(negedge clk);
      checks++;
      if (ack !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL draw_wait: cycle %0d ack=%b busy=%b want ack=0 busy=1", n, ack, busy);
      end
      if (perturb && n == 1) begin
        seed_load = 1'b1;
        seed = 6'($urandom);
        limit = 24'($urandom);
      end
      if (n == 2) seed_load = 1'b0;
    end
    @(negedge clk);
    seed_load = 1'b0;
    eack = '0;
    eack[who] = 1'b1;
    checks++;
    if (ack !== eack || rdata !== er || timeout !== eto || busy !== 1'b1) begin
      errors++;
      $display("FAIL ack_cycle: ack=%b rdata=%h to=%b busy=%b want ack=%b rdata=%h to=%b busy=1",
               ack, rdata, timeout, busy, eack, er, eto);
    end
    got_r = rdata;
    got_to = timeout;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    checks++;
    if (ack !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle: ack=%b busy=%b want 0 0", ack, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (ack !== '0 || rdata !== '0 || timeout !== 1'b0 || busy !== 1'b0 ||
        dut.u_lfsr.out !== 6'h00) begin
      errors++;
      $display("FAIL reset_state: ack=%b rdata=%h to=%b busy=%b lfsr=%h want all 0",
               ack, rdata, timeout, busy, dut.u_lfsr.out);
    end
    @(negedge clk);
    reset = 1'b0;
    m_ptr = N_REQ - 1;
  endtask

  task automatic test_first_grant();
    int who; logic [5:0] r; logic to;
    do_reset();
    req = 4'b0001;
    limit = {N_REQ{6'h3F}};
    serve(1'b0, who, r, to);
    checks++;
    if (who != 0 || r !== 6'h01 || to !== 1'b0) begin
      errors++;
      $display("FAIL first_grant: who=%0d rdata=%h to=%b want 0 01 0", who, r, to);
    end
    req = '0;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int who; logic [5:0] r; logic to;
    do_reset();
    req = 4'b1111;
    limit = {N_REQ{6'h3F}};
    for (int t = 0; t < 5; t++) begin
      serve(1'b0, who, r, to);
      checks++;
      if (who != t % N_REQ) begin
        errors++;
        $display("FAIL rr_order: slot %0d served %0d want %0d", t, who, t % N_REQ);
      end
      if (t < 4) idle_cycle();
    end
    req = '0;
    idle_cycle();
  endtask

  task automatic test_rejection();
    int who; logic [5:0] r; logic to;
    seed_load = 1'b1; seed = 6'h00; m_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; m_load = 1'b0;
    req = 4'b0100;
    limit = {N_REQ{6'h3F}};
    limit[17:12] = 6'h00;
    serve(1'b0, who, r, to);
    checks++;
    if (who != 2 || r !== 6'h00 || to !== 1'b1) begin
      errors++;
      $display("FAIL rejection_timeout: who=%0d rdata=%h to=%b want 2 00 1", who, r, to);
    end
    req = '0;
    idle_cycle();
  endtask

  task automatic test_seed();
    int who; logic [5:0] r; logic to;
    seed_load = 1'b1; seed = 6'h3F; m_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; m_load = 1'b0;
    req = 4'b0001;
    limit = {N_REQ{6'h3F}};
    serve(1'b0, who, r, to);
    checks++;
    if (r !== 6'h01) begin
      errors++;
      $display("FAIL seed_lockup: rdata=%h want 01", r);
    end
    req = '0;
    idle_cycle();
    req = 4'b0010;
    limit[11:6] = 6'h05;
    serve(1'b1, who, r, to);
    req = '0;
    idle_cycle();
  endtask

  task automatic test_seed_and_req();
    int who; logic [5:0] r, s; logic to;
    s = 6'($urandom_range(0, 62));
    seed_load = 1'b1; seed = s; m_load = 1'b1;
    req = 4'b1000;
    limit = {N_REQ{6'h3F}};
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL seed_defers_grant: busy=%b want 0", busy);
    end
    @(negedge clk);
    seed_load = 1'b0; m_load = 1'b0;
    serve(1'b0, who, r, to);
    checks++;
    if (who != 3 || r !== step(s)) begin
      errors++;
      $display("FAIL seed_then_grant: who=%0d rdata=%h want 3 %h", who, r, step(s));
    end
    req = '0;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int who; logic [5:0] r; logic to;
    seed_load = 1'b1; seed = 6'h00; m_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; m_load = 1'b0;
    req = 4'b0001;
    limit = '0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== '0 || busy !== 1'b0 || rdata !== '0 || timeout !== 1'b0 ||
        dut.u_lfsr.out !== 6'h00) begin
      errors++;
      $display("FAIL reset_mid_draw: ack=%b busy=%b rdata=%h to=%b lfsr=%h want all 0",
               ack, busy, rdata, timeout, dut.u_lfsr.out);
    end
    @(negedge clk);
    reset = 1'b0;
    m_ptr = N_REQ - 1;
    req = 4'b1010;
    limit = {N_REQ{6'h3F}};
    serve(1'b0, who, r, to);
    checks++;
    if (who != 1) begin
      errors++;
      $display("FAIL rearb_after_reset: served %0d want 1", who);
    end
    req[1] = 1'b0;
    idle_cycle();
    serve(1'b0, who, r, to);
    checks++;
    if (who != 3) begin
      errors++;
      $display("FAIL rearb_second: served %0d want 3", who);
    end
    req = '0;
    idle_cycle();
    // reset landing in the ack cycle must drop ack at once
    req = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== '0 || rdata !== '0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: ack=%b rdata=%h to=%b want 0", ack, rdata, timeout);
    end
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    m_ptr = N_REQ - 1;
  endtask

  task automatic test_random();
    int who; logic [5:0] r; logic to;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      req = req | 4'($urandom_range(1, 15));
      limit = 24'($urandom);
      serve(1'($urandom), who, r, to);
      if (who >= 0) req[who] = 1'b0;
      idle_cycle();
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_rejection();
    test_seed();
    test_seed_and_req();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
